mac_operand_issuer: RTL and testbench
=====================================

// Module: mac_operand_issuer
// PURPOSE
//   Transmit side of the MAC operand interface: collects byte-serial input (A then B),
//   queues complete operand pairs and issues them as {data_a, data_b, clear_mult, valid}
//   with a ready/valid handshake. Sits between the pin-level byte loader and pipeline_registers.
//   Provides backpressure on bytes, an accumulator-clear tag per pair and a sticky overflow flag.
// PARAMETERS
//   DATA_W   8   operand width in bits
//   DEPTH    2   pair-FIFO entries; power of 2, >= 2
//   CNT_W    8   width of issued-pair counter
// PORTS
//   clk             in   1        system clock, all state on rising edge
//   rst             in   1        asynchronous, active-high reset
//   byte_in         in   DATA_W   operand byte, sampled when byte_strobe=1
//   byte_strobe     in   1        one-cycle byte-valid pulse
//   cmd_clear       in   1        pulse: tag the next pushed pair with clear_mult=1
//   flush           in   1        synchronous flush of partial pair, FIFO, flags
//   ready_in        in   1        downstream accepts the current pair
//   data_a_out      out  DATA_W   head-of-queue operand A
//   data_b_out      out  DATA_W   head-of-queue operand B
//   clear_mult_out  out  1        head pair carries accumulator clear
//   valid_out       out  1        head pair is valid
//   byte_ready      out  1        byte_strobe will be accepted this cycle
//   overflow        out  1        sticky: a byte was dropped
//   pair_count      out  CNT_W    number of pairs handed off (valid_out & ready_in)
// BEHAVIOUR
//   - Reset (async, rst=1): FSM=WAIT_A, FIFO empty, clear_pending=0; outputs: data_*=0,
//     clear_mult_out=0, valid_out=0, byte_ready=1, overflow=0, pair_count=0. Reset mid-pair
//     discards latched A and all queued pairs.
//   - FSM WAIT_A: accepted byte -> latch A, go WAIT_B. WAIT_B: accepted byte -> push
//     {A, byte_in, clear_pending | cmd_clear}, clear clear_pending, go WAIT_A.
//   - byte_ready = (state==WAIT_A) | ~full. No combinational path from ready_in
//     (push when full is refused even if a pop occurs the same cycle).
//   - byte_strobe & ~byte_ready: byte dropped, FSM unchanged, overflow<=1 (sticky).
//   - cmd_clear sets clear_pending; cleared on the push that consumes it. cmd_clear in the
//     same cycle as the B push tags that pair; repeated cmd_clear before a push collapses to one.
//   - valid_out = ~empty. data_*_out/clear_mult_out = head entry when valid_out=1, else 0.
//   - Pop when valid_out & ready_in; pair_count increments, wraps 2^CNT_W-1 -> 0, reset-only.
//   - Latency: B byte accepted in cycle N with FIFO empty -> valid_out=1 in cycle N+1.
//   - Simultaneous push and pop (not full): both occur, occupancy unchanged, order preserved.
//   - Holding: while valid_out & ~ready_in, head outputs stay stable.
//   - flush (priority over strobe/cmd_clear, no overflow raised): FSM=WAIT_A, FIFO empty,
//     clear_pending=0, overflow=0; pair_count kept. A pop coinciding with flush still counts.
// STRUCTURE
//   - Shared header mac_defs.vh: DATA_W default, FSM state encodings (WAIT_A/WAIT_B),
//     pair-entry layout {clear, a, b} width macro, shared with pipeline_registers bench.
//   - Sub-module pair_fifo: DEPTH-entry register FIFO, push/pop/full/empty, wrap-around
//     pointers with extra MSB for full/empty; issuer holds FSM, tag, overflow, counter.
// TESTING
//   - Reset: assert rst mid-WAIT_B with 1 pair queued -> all outputs at reset values, next
//     bytes 0x11,0x22 -> pair (0x11,0x22) valid_out=1 one cycle after 0x22.
//   - Basic: bytes 0x03,0x05, ready_in=1 -> one-cycle valid with a=0x03,b=0x05,clear=0; pair_count=1.
//   - Clear tag: cmd_clear then 0x07,0x09 -> clear_mult_out=1; following pair 0x01,0x02 -> clear=0.
//   - Backpressure: ready_in=0, send 3 pairs (DEPTH=2) -> byte_ready=0 after 4th+1 byte
//     latched as A; 6th byte dropped, overflow=1; release ready_in -> pairs issued in order.
//   - Concurrent push/pop at occupancy 1 -> occupancy stays 1, order preserved, pair_count +1.
//   - Flush with A latched and 2 queued -> valid_out=0, overflow=0, pair_count unchanged;
//     wrap: 256 pairs issued -> pair_count returns to 0.

Source files
------------

// File: rtl/mac_operand_issuer_pkg.sv
// Shared definitions for the MAC operand issuer: default operand width,
// byte-collector states and the packed pair-entry layout {clear, a, b}.
package mac_operand_issuer_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } issuer_state_t;

  // Width of one queued pair entry: clear tag + operand A + operand B.
  function automatic int unsigned pair_w(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/mac_operand_issuer_pair_fifo.sv
// DEPTH-entry register FIFO for operand pairs. Pointers carry one extra MSB
// so full and empty are distinguished without an occupancy counter.
module pair_fifo #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_operand_issuer.sv
// Transmit side of the MAC operand interface: collects A then B bytes, tags
// pairs with a pending accumulator clear, queues them and issues them with a
// ready/valid handshake. Tracks dropped bytes and the number of issued pairs.
module mac_operand_issuer
  import mac_operand_issuer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_strobe,
  input  logic              cmd_clear,
  input  logic              flush,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_a_out,
  output logic [DATA_W-1:0] data_b_out,
  output logic              clear_mult_out,
  output logic              valid_out,
  output logic              byte_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  pair_count
);

  localparam int unsigned PW = pair_w(DATA_W);

  issuer_state_t     state;
  issuer_state_t     state_nxt;
  logic [DATA_W-1:0] a_reg;
  logic              clear_pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     head;
  logic [PW-1:0]     push_data;
  logic              accept;
  logic              push;
  logic              pop;

  // byte_ready depends only on registered state, never on ready_in.
  assign byte_ready = (state == WAIT_A) | ~fifo_full;
  assign accept     = byte_strobe & byte_ready & ~flush;
  assign push       = accept & (state == WAIT_B);
  assign pop        = ~fifo_empty & ready_in;
  assign push_data  = {clear_pending | cmd_clear, a_reg, byte_in};

  pair_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid_out      = ~fifo_empty;
  assign data_a_out     = valid_out ? head[2*DATA_W-1:DATA_W] : '0;
  assign data_b_out     = valid_out ? head[DATA_W-1:0]        : '0;
  assign clear_mult_out = valid_out & head[PW-1];

  // Collector state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_A;
    else     state <= state_nxt;
  end

  // Next state: each accepted byte toggles A/B; flush returns to WAIT_A.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = WAIT_A;
    end else if (accept) begin
      state_nxt = (state == WAIT_A) ? WAIT_B : WAIT_A;
    end
  end

  // Operand A holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               a_reg <= '0;
    else if (accept && (state == WAIT_A))  a_reg <= byte_in;
  end

  // Pending clear: consumed by the push that carries it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            clear_pending <= 1'b0;
    else if (flush)     clear_pending <= 1'b0;
    else if (push)      clear_pending <= 1'b0;
    else if (cmd_clear) clear_pending <= 1'b1;
  end

  // Sticky overflow on a dropped byte; flush clears it without raising it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overflow <= 1'b0;
    else if (flush)                     overflow <= 1'b0;
    else if (byte_strobe && !byte_ready) overflow <= 1'b1;
  end

  // Issued-pair counter; a pop in the flush cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pair_count <= '0;
    else if (pop) pair_count <= pair_count + 1'b1;
  end

endmodule

// File: tb/tb_mac_operand_issuer.sv
module tb_mac_operand_issuer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] byte_in;
  logic              byte_strobe;
  logic              cmd_clear;
  logic              flush;
  logic              ready_in;
  logic [DATA_W-1:0] data_a_out;
  logic [DATA_W-1:0] data_b_out;
  logic              clear_mult_out;
  logic              valid_out;
  logic              byte_ready;
  logic              overflow;
  logic [CNT_W-1:0]  pair_count;

  always #5 clk = ~clk;

  mac_operand_issuer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_in        (byte_in),
    .byte_strobe    (byte_strobe),
    .cmd_clear      (cmd_clear),
    .flush          (flush),
    .ready_in       (ready_in),
    .data_a_out     (data_a_out),
    .data_b_out     (data_b_out),
    .clear_mult_out (clear_mult_out),
    .valid_out      (valid_out),
    .byte_ready     (byte_ready),
    .overflow       (overflow),
    .pair_count     (pair_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: a half-built pair, a queue of complete pairs.
  bit          m_have_a;
  logic [7:0]  m_a;
  bit          m_clr_pend;
  bit          m_ovf;
  logic [7:0]  m_cnt;
  logic [16:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_a   = 0;
    m_a        = '0;
    m_clr_pend = 0;
    m_ovf      = 0;
    m_cnt      = '0;
    m_q.delete();
  endtask

  task automatic compare_all();
    logic [16:0] hd;
    bit          v;
    v  = (m_q.size() != 0);
    hd = v ? m_q[0] : '0;
    check("valid_out",  valid_out,      v);
    check("data_a",     data_a_out,     hd[15:8]);
    check("data_b",     data_b_out,     hd[7:0]);
    check("clear_mult", clear_mult_out, hd[16]);
    check("byte_ready", byte_ready,     (!m_have_a) || (m_q.size() < DEPTH));
    check("overflow",   overflow,       m_ovf);
    check("pair_count", pair_count,     m_cnt);
  endtask

  // Apply the rules for one clock with the given inputs.
  task automatic model_update(input logic [7:0] b, input bit s, input bit c,
                              input bit f, input bit r);
    bit can_take;
    bit do_pop;
    bit pushed;
    can_take = (!m_have_a) || (m_q.size() < DEPTH);
    do_pop   = (m_q.size() != 0) && r;
    pushed   = 0;
    if (do_pop) m_cnt++;
    if (f) begin
      m_have_a   = 0;
      m_clr_pend = 0;
      m_ovf      = 0;
      m_q.delete();
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (s) begin
        if (!can_take) m_ovf = 1;
        else if (!m_have_a) begin
          m_a      = b;
          m_have_a = 1;
        end else begin
          m_q.push_back({m_clr_pend | c, m_a, b});
          m_have_a   = 0;
          m_clr_pend = 0;
          pushed     = 1;
        end
      end
      if (c && !pushed) m_clr_pend = 1;
    end
  endtask

  // Called at a falling edge: drive, check current outputs, advance one cycle.
  task automatic step(input logic [7:0] b, input bit s, input bit c,
                      input bit f, input bit r);
    byte_in     = b;
    byte_strobe = s;
    cmd_clear   = c;
    flush       = f;
    ready_in    = r;
    #1;
    compare_all();
    model_update(b, s, c, f, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] pc_saved;

  initial begin
    byte_in = '0; byte_strobe = 0; cmd_clear = 0; flush = 0; ready_in = 0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;

    // Basic pair, downstream ready.
    step(8'h03, 1, 0, 0, 1);
    step(8'h05, 1, 0, 0, 1);
    check("basic_valid", valid_out, 1);
    check("basic_a", data_a_out, 8'h03);
    check("basic_b", data_b_out, 8'h05);
    step(8'h00, 0, 0, 0, 1);
    check("basic_cnt", pair_count, 1);
    check("basic_gone", valid_out, 0);

    // Clear tag applies to the next pair only.
    step(8'h00, 0, 1, 0, 0);
    step(8'h07, 1, 0, 0, 0);
    step(8'h09, 1, 0, 0, 0);
    check("clr_tag", clear_mult_out, 1);
    step(8'h01, 1, 0, 0, 1);
    step(8'h02, 1, 0, 0, 1);
    check("clr_next_a", data_a_out, 8'h01);
    check("clr_next", clear_mult_out, 0);
    step(8'h00, 0, 0, 0, 1);

    // Backpressure: two pairs fill the queue, fifth byte becomes A, sixth drops.
    for (int i = 1; i <= 5; i++) step(8'(8'h20 + i), 1, 0, 0, 0);
    check("bp_ready_low", byte_ready, 0);
    step(8'h26, 1, 0, 0, 0);
    check("bp_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) step(8'h00, 0, 0, 0, 1);

    // Concurrent push/pop at occupancy 1.
    step(8'h30, 1, 0, 0, 0);
    step(8'hA1, 1, 0, 0, 0);
    pc_saved = pair_count;
    step(8'hB1, 1, 0, 0, 1);
    check("cc_valid", valid_out, 1);
    check("cc_a", data_a_out, 8'hA1);
    check("cc_cnt", pair_count, pc_saved + 8'd1);
    step(8'h00, 0, 0, 0, 1);

    // Flush with A latched, two queued and overflow set.
    for (int i = 0; i < 5; i++) step(8'(8'h40 + i), 1, 0, 0, 0);
    step(8'h4F, 1, 0, 0, 0);
    pc_saved = pair_count;
    step(8'h50, 1, 1, 1, 0);
    check("fl_valid", valid_out, 0);
    check("fl_ovf", overflow, 0);
    check("fl_cnt", pair_count, pc_saved);
    check("fl_ready", byte_ready, 1);

    // Asynchronous reset while waiting for B with one pair queued.
    step(8'h61, 1, 0, 0, 0);
    step(8'h62, 1, 0, 0, 0);
    step(8'h63, 1, 1, 0, 0);
    rst = 1;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_a", data_a_out, 0);
    check("rst_ready", byte_ready, 1);
    check("rst_cnt", pair_count, 0);
    check("rst_clr", clear_mult_out, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(8'h11, 1, 0, 0, 0);
    step(8'h22, 1, 0, 0, 0);
    check("rst_pair_v", valid_out, 1);
    check("rst_pair_a", data_a_out, 8'h11);
    check("rst_pair_b", data_b_out, 8'h22);
    check("rst_pair_c", clear_mult_out, 0);

    // Counter wrap: 256 issued pairs return pair_count to its start value.
    step(8'h00, 0, 0, 1, 0);
    pc_saved = pair_count;
    for (int i = 0; i < 256; i++) begin
      step(8'(i), 1, 0, 0, 1);
      step(8'(~i), 1, 0, 0, 1);
    end
    step(8'h00, 0, 0, 0, 1);
    check("wrap_cnt", pair_count, pc_saved);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      step(8'($urandom), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 50));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
